// File: rtl/sop_term_engine_pkg.sv
// Shared types and sizing for the sum-of-products term engine.
// Cubes are stored with don't-care bits zeroed so a stored term has one canonical encoding.
package sop_pkg;

  localparam int N_IN      = 11;
  localparam int MAX_TERMS = 32;
  localparam int IDX_W     = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
  localparam int CNT_W     = $clog2(MAX_TERMS + 1);
  localparam int ONES_W    = N_IN + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESULT,
    SWEEP
  } state_t;

  typedef struct packed {
    logic [N_IN-1:0] mask;
    logic [N_IN-1:0] value;
  } term_t;

  localparam logic [IDX_W-1:0] NO_HIT_IDX = '1;

  function automatic term_t make_term(input logic [N_IN-1:0] mask,
                                      input logic [N_IN-1:0] value);
    term_t t;
    t.mask  = mask;
    t.value = value & mask;
    return t;
  endfunction

endpackage

// File: rtl/sop_term_engine_if.sv
// Load / evaluate / result / sweep signal bundle of the term engine.
// The master side drives requests; the slave side is the engine itself.
interface sop_term_engine_if;
  import sop_pkg::*;

  logic              clear;
  logic              load_valid;
  logic              load_ready;
  logic [N_IN-1:0]   load_mask;
  logic [N_IN-1:0]   load_value;
  logic [CNT_W-1:0]  term_count;
  logic              eval_valid;
  logic              eval_ready;
  logic [N_IN-1:0]   eval_vec;
  logic              res_valid;
  logic              res_ready;
  logic              res_out;
  logic [IDX_W-1:0]  res_hit_idx;
  logic              sweep_start;
  logic              sweep_busy;
  logic              sweep_done;
  logic [ONES_W-1:0] sweep_ones;

  modport master (
    output clear, load_valid, load_mask, load_value, eval_valid, eval_vec,
           res_ready, sweep_start,
    input  load_ready, term_count, eval_ready, res_valid, res_out,
           res_hit_idx, sweep_busy, sweep_done, sweep_ones
  );

  modport slave (
    input  clear, load_valid, load_mask, load_value, eval_valid, eval_vec,
           res_ready, sweep_start,
    output load_ready, term_count, eval_ready, res_valid, res_out,
           res_hit_idx, sweep_busy, sweep_done, sweep_ones
  );

endinterface

// File: rtl/sop_term_match.sv
// Single-cube compare: vec lies inside the cube when every care bit equals its literal.
module sop_term_match
  import sop_pkg::*;
(
   input  logic [N_IN-1:0] vec,
   input  logic [N_IN-1:0] mask,
   input  logic [N_IN-1:0] value,
   output logic            match
);

   assign match = (((vec ^ value) & mask) == '0);

endmodule

// File: rtl/sop_term_engine.sv
// Sequential SOP evaluator: scans a loaded implicant table one term per cycle with
// first-hit early exit, either for a single vector or across the full input space.
module sop_term_engine
  import sop_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   sop_term_engine_if.slave bus
);

   state_t            state;
   term_t             tbl [MAX_TERMS];
   logic [CNT_W-1:0]  term_count;
   logic [IDX_W-1:0]  idx;
   logic [N_IN-1:0]   vec_q;
   logic              res_valid_q;
   logic              res_out_q;
   logic [IDX_W-1:0]  res_hit_idx_q;
   logic              sweep_done_q;
   logic [ONES_W-1:0] sweep_ones_q;

   term_t cur_term;
   logic  term_match;
   logic  hit;
   logic  last_term;
   logic  load_ready;
   logic  load_fire;

   assign cur_term = tbl[idx];

   sop_term_match u_match (
      .vec   (vec_q),
      .mask  (cur_term.mask),
      .value (cur_term.value),
      .match (term_match)
   );

   // An empty table can never hit; the stale entry at idx 0 is ignored.
   assign hit       = term_match && (term_count != '0);
   assign last_term = (term_count == '0) || ((CNT_W'(idx) + CNT_W'(1)) == term_count);

   assign load_ready = (state == IDLE) && (term_count < CNT_W'(MAX_TERMS));
   assign load_fire  = !rst && load_ready && bus.load_valid && !bus.clear &&
                       !bus.eval_valid && !bus.sweep_start;

   assign bus.load_ready  = load_ready;
   assign bus.eval_ready  = (state == IDLE);
   assign bus.term_count  = term_count;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_out     = res_out_q;
   assign bus.res_hit_idx = res_hit_idx_q;
   assign bus.sweep_busy  = (state == SWEEP);
   assign bus.sweep_done  = sweep_done_q;
   assign bus.sweep_ones  = sweep_ones_q;

   // NOTE: the table array has no reset; emptying it means zeroing term_count, and
   // entries at or above term_count are never consulted.
   always_ff @(posedge clk) begin
      if (load_fire) begin
         tbl[term_count[IDX_W-1:0]] <= make_term(bus.load_mask, bus.load_value);
      end
   end

   // NOTE: reset is synchronous, so it sits inside the clocked block and wins over
   // every state-dependent update below.
   always_ff @(posedge clk) begin
      sweep_done_q <= 1'b0;
      if (rst) begin
         state         <= IDLE;
         term_count    <= '0;
         idx           <= '0;
         vec_q         <= '0;
         res_valid_q   <= 1'b0;
         res_out_q     <= 1'b0;
         res_hit_idx_q <= '0;
         sweep_ones_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.clear) begin
                  term_count <= '0;
               end else if (bus.eval_valid) begin
                  vec_q <= bus.eval_vec;
                  idx   <= '0;
                  state <= SCAN;
               end else if (bus.sweep_start) begin
                  vec_q        <= '0;
                  idx          <= '0;
                  sweep_ones_q <= '0;
                  state        <= SWEEP;
               end else if (load_fire) begin
                  term_count <= term_count + CNT_W'(1);
               end
            end

            SCAN: begin
               if (hit || last_term) begin
                  res_valid_q   <= 1'b1;
                  res_out_q     <= hit;
                  res_hit_idx_q <= hit ? idx : NO_HIT_IDX;
                  state         <= RESULT;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end

            RESULT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end

            SWEEP: begin
               // Each minterm finishes on its first hit or after the last stored term.
               if (hit || last_term) begin
                  if (hit) begin
                     sweep_ones_q <= sweep_ones_q + ONES_W'(1);
                  end
                  idx <= '0;
                  if (vec_q == '1) begin
                     sweep_done_q <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     vec_q <= vec_q + N_IN'(1);
                  end
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sop_term_engine.sv
// Scoreboard bench for sop_term_engine: expected eval results come from a bench-side
// list of loaded cubes and are queued at stimulus time, then popped when res_valid rises.
module tb_sop_term_engine;
   import sop_pkg::*;

   localparam int SWEEP_BUDGET = 2 * (1 << N_IN) + 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sop_term_engine_if bus();

   sop_term_engine dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic             out;
      logic [IDX_W-1:0] idx;
      int               lat;
   } exp_t;

   exp_t            sb [$];
   logic [N_IN-1:0] m_mask [$];
   logic [N_IN-1:0] m_val  [$];
   int checks = 0;
   int errors = 0;

   function automatic exp_t model(input logic [N_IN-1:0] v);
      exp_t e;
      bit   found = 1'b0;
      e.out = 1'b0;
      e.idx = '1;
      e.lat = (m_mask.size() == 0) ? 1 : m_mask.size();
      for (int i = 0; i < m_mask.size(); i++) begin
         if (!found && (((v ^ m_val[i]) & m_mask[i]) == '0)) begin
            found = 1'b1;
            e.out = 1'b1;
            e.idx = i[IDX_W-1:0];
            e.lat = i + 1;
         end
      end
      return e;
   endfunction

   task automatic idle_inputs();
      bus.clear       = 1'b0;
      bus.load_valid  = 1'b0;
      bus.load_mask   = '0;
      bus.load_value  = '0;
      bus.eval_valid  = 1'b0;
      bus.eval_vec    = '0;
      bus.res_ready   = 1'b0;
      bus.sweep_start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({bus.term_count, bus.res_valid, bus.res_out, bus.res_hit_idx, bus.sweep_busy,
           bus.sweep_done, bus.sweep_ones, bus.load_ready, bus.eval_ready} !==
          {CNT_W'(0), 1'b0, 1'b0, IDX_W'(0), 1'b0, 1'b0, ONES_W'(0), 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL %s: cnt=%0d rv=%b ro=%b idx=%0d busy=%b done=%b ones=%0d lr=%b er=%b, want cnt=0 rv=0 ro=0 idx=0 busy=0 done=0 ones=0 lr=1 er=1",
                  name, bus.term_count, bus.res_valid, bus.res_out, bus.res_hit_idx,
                  bus.sweep_busy, bus.sweep_done, bus.sweep_ones, bus.load_ready, bus.eval_ready);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_mask.delete();
      m_val.delete();
      sb.delete();
   endtask

   task automatic load_term(input logic [N_IN-1:0] mask, input logic [N_IN-1:0] value);
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_mask  = mask;
      bus.load_value = value;
      @(negedge clk);
      bus.load_valid = 1'b0;
      if (m_mask.size() < MAX_TERMS) begin
         m_mask.push_back(mask);
         m_val.push_back(value);
      end
   endtask

   task automatic run_eval(input logic [N_IN-1:0] v, input int hold, input bit also_load);
      exp_t             e;
      int               lat;
      logic [CNT_W-1:0] cnt_before;
      sb.push_back(model(v));
      @(negedge clk);
      cnt_before = bus.term_count;
      checks++;
      if (bus.eval_ready !== 1'b1) begin
         errors++;
         $display("FAIL eval_ready_idle vec=%h: got %b want 1", v, bus.eval_ready);
      end
      bus.eval_valid = 1'b1;
      bus.eval_vec   = v;
      if (also_load) begin
         bus.load_valid = 1'b1;
         bus.load_mask  = '1;
         bus.load_value = '0;
      end
      @(negedge clk);
      bus.eval_valid = 1'b0;
      bus.load_valid = 1'b0;
      checks++;
      if ({bus.eval_ready, bus.res_valid} !== 2'b00) begin
         errors++;
         $display("FAIL scan_flags vec=%h: eval_ready=%b res_valid=%b want 0 0", v, bus.eval_ready, bus.res_valid);
      end
      if (also_load) begin
         checks++;
         if (bus.term_count !== cnt_before) begin
            errors++;
            $display("FAIL eval_over_load: term_count=%0d want %0d", bus.term_count, cnt_before);
         end
      end
      lat = 0;
      while (bus.res_valid !== 1'b1 && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      checks++;
      if (bus.res_valid !== 1'b1) begin
         errors++;
         $display("FAIL eval_timeout vec=%h: res_valid=%b want 1 within 64 cycles", v, bus.res_valid);
      end
      checks++;
      if ({bus.res_out, bus.res_hit_idx} !== {e.out, e.idx}) begin
         errors++;
         $display("FAIL eval_result vec=%h: out=%b idx=%h want out=%b idx=%h", v, bus.res_out, bus.res_hit_idx, e.out, e.idx);
      end
      checks++;
      if (lat != e.lat) begin
         errors++;
         $display("FAIL eval_latency vec=%h: %0d cycles want %0d", v, lat, e.lat);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if ({bus.res_valid, bus.res_out, bus.res_hit_idx, bus.eval_ready} !== {1'b1, e.out, e.idx, 1'b0}) begin
            errors++;
            $display("FAIL result_hold cycle %0d: rv=%b out=%b idx=%h er=%b want rv=1 out=%b idx=%h er=0",
                     h, bus.res_valid, bus.res_out, bus.res_hit_idx, bus.eval_ready, e.out, e.idx);
         end
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      checks++;
      if ({bus.res_valid, bus.eval_ready} !== 2'b01) begin
         errors++;
         $display("FAIL result_release: res_valid=%b eval_ready=%b want 0 1", bus.res_valid, bus.eval_ready);
      end
   endtask

   task automatic run_sweep(input int exp_ones);
      int cyc = 0;
      @(negedge clk);
      bus.sweep_start = 1'b1;
      @(negedge clk);
      bus.sweep_start = 1'b0;
      checks++;
      if ({bus.sweep_busy, bus.sweep_ones, bus.eval_ready} !== {1'b1, ONES_W'(0), 1'b0}) begin
         errors++;
         $display("FAIL sweep_start: busy=%b ones=%0d er=%b want 1 0 0", bus.sweep_busy, bus.sweep_ones, bus.eval_ready);
      end
      while (bus.sweep_done !== 1'b1 && cyc < SWEEP_BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (bus.sweep_done !== 1'b1) begin
         errors++;
         $display("FAIL sweep_timeout: no sweep_done within %0d cycles", SWEEP_BUDGET);
      end
      checks++;
      if ({bus.sweep_ones, bus.sweep_busy} !== {ONES_W'(exp_ones), 1'b0}) begin
         errors++;
         $display("FAIL sweep_result: ones=%0d busy=%b want ones=%0d busy=0", bus.sweep_ones, bus.sweep_busy, exp_ones);
      end
      @(negedge clk);
      checks++;
      if ({bus.sweep_done, bus.sweep_ones} !== {1'b0, ONES_W'(exp_ones)}) begin
         errors++;
         $display("FAIL sweep_after: done=%b ones=%0d want done=0 ones=%0d", bus.sweep_done, bus.sweep_ones, exp_ones);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      check_reset_outputs("reset_values");
   endtask

   task automatic test_single_term();
      apply_reset();
      load_term(11'h7FF, 11'h001);
      run_eval(11'h001, 0, 1'b0);
      run_eval(11'h002, 0, 1'b0);
   endtask

   task automatic test_early_exit();
      apply_reset();
      load_term(11'h7FF, 11'h010);
      load_term(11'h001, 11'h001);
      run_eval(11'h003, 0, 1'b0);
      run_eval(11'h010, 0, 1'b0);
      run_eval(11'h000, 0, 1'b1);
      load_term(11'h00F, 11'h7F5);
      run_eval(11'h7F4, 0, 1'b0);
      run_eval(11'h005, 0, 1'b0);
   endtask

   task automatic test_sweep();
      apply_reset();
      load_term(11'h780, 11'h000);
      run_sweep(128);
      apply_reset();
      run_sweep(0);
   endtask

   task automatic test_full_table();
      apply_reset();
      for (int i = 0; i < MAX_TERMS; i++) load_term(11'h7FF, N_IN'(i));
      @(negedge clk);
      checks++;
      if ({bus.term_count, bus.load_ready} !== {CNT_W'(MAX_TERMS), 1'b0}) begin
         errors++;
         $display("FAIL table_full: cnt=%0d lr=%b want %0d 0", bus.term_count, bus.load_ready, MAX_TERMS);
      end
      load_term(11'h000, 11'h000);
      checks++;
      if (bus.term_count !== CNT_W'(MAX_TERMS)) begin
         errors++;
         $display("FAIL overflow_load: cnt=%0d want %0d", bus.term_count, MAX_TERMS);
      end
      run_eval(11'h01F, 0, 1'b0);
      run_eval(11'h7FF, 0, 1'b0);
      @(negedge clk);
      bus.clear      = 1'b1;
      bus.load_valid = 1'b1;
      @(negedge clk);
      bus.clear      = 1'b0;
      bus.load_valid = 1'b0;
      m_mask.delete();
      m_val.delete();
      checks++;
      if ({bus.term_count, bus.load_ready} !== {CNT_W'(0), 1'b1}) begin
         errors++;
         $display("FAIL clear: cnt=%0d lr=%b want 0 1", bus.term_count, bus.load_ready);
      end
      run_eval(11'h000, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      load_term(11'h7FF, 11'h001);
      run_eval(11'h001, 5, 1'b0);
      run_eval(11'h001, 0, 1'b0);
   endtask

   task automatic test_rst_mid();
      int bad = 0;
      apply_reset();
      load_term(11'h7FF, 11'h001);
      load_term(11'h7FF, 11'h002);
      load_term(11'h7FF, 11'h003);
      @(negedge clk);
      bus.eval_valid = 1'b1;
      bus.eval_vec   = 11'h000;
      @(negedge clk);
      bus.eval_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("rst_mid_scan");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.res_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rst_scan_no_result: res_valid seen %0d cycles want 0", bad);
      end

      m_mask.delete();
      m_val.delete();
      load_term(11'h780, 11'h000);
      @(negedge clk);
      bus.sweep_start = 1'b1;
      @(negedge clk);
      bus.sweep_start = 1'b0;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("rst_mid_sweep");
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.sweep_done !== 1'b0 || bus.sweep_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rst_sweep_no_done: done/busy seen %0d cycles want 0", bad);
      end
      m_mask.delete();
      m_val.delete();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_term();
      test_early_exit();
      test_sweep();
      test_full_table();
      test_back_to_back();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
